ddr_rw_sched: RTL and testbench
===============================

# ddr_rw_sched

Read/write mode scheduler for the DDR3 user-side datapath. Converts debounced one-cycle key pulses (from the key filter) into mutually exclusive `rd_en` / `wr_en` levels for the DDR3 read and write paths. A mode change never cuts an in-flight burst: the block first drops both enables, waits for the DDR3 controller to go idle, and only then enables the new mode. A bounded timeout prevents a hang if the controller never reports idle.

## Interface
Parameters:
- `FREQ`, default 28'd25_000_000: input clock frequency in Hz.
- `TIMEOUT_MS`, default 100: maximum drain wait in ms. Timeout cycle count `TMO_CYC = FREQ/1000*TIMEOUT_MS`, held in a 32-bit constant.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `key_rd`  in  1: debounced read-key pulse, one cycle high per press.
- `key_wr`  in  1: debounced write-key pulse, one cycle high per press.
- `burst_busy`  in  1: DDR3 controller has a burst in progress.
- `rd_en`  out  1: read path enable, level.
- `wr_en`  out  1: write path enable, level.
- `mode`  out  2: current FSM state (encoding in package).
- `timeout_err`  out  1: sticky flag; set when a drain times out; cleared only by `rst`.

## Operation
- FSM states: IDLE=0, READ=1, WRITE=2, DRAIN=3.
- Target register `tgt` (IDLE/READ/WRITE) holds the state DRAIN exits to.
- Enable outputs by state:
  - `rd_en = 1` only in READ.
  - `wr_en = 1` only in WRITE.
  - Both 0 in IDLE and DRAIN.
  - `rd_en & wr_en` is never 1.
- Transitions from IDLE:
  - `key_rd` -> READ.
  - else `key_wr` -> WRITE.
- Transitions from READ:
  - `key_rd` -> DRAIN, `tgt` = IDLE.
  - else `key_wr` -> DRAIN, `tgt` = WRITE.
- Transitions from WRITE:
  - `key_wr` -> DRAIN, `tgt` = IDLE.
  - else `key_rd` -> DRAIN, `tgt` = READ.
- Keys during DRAIN retarget; the latest request wins:
  - `key_rd`: `tgt` = (`tgt`==READ) ? IDLE : READ.
  - else `key_wr`: `tgt` = (`tgt`==WRITE) ? IDLE : WRITE.
- DRAIN exit:
  - Exits to `tgt` on the first sampled cycle with `burst_busy`=0.
  - A key pulse in the same cycle as the exit updates `tgt` first; the new `tgt` is used.
- Simultaneous `key_rd` and `key_wr`: `key_rd` has priority; `key_wr` is ignored that cycle in every state.
- Drain timer:
  - Counts cycles in DRAIN with `burst_busy`=1.
  - Clears on DRAIN entry and whenever `burst_busy`=0.
  - Saturates; no wrap.
  - At count `TMO_CYC-1` with `burst_busy` still 1: force exit to `tgt` and set `timeout_err`.
- `burst_busy` is ignored outside DRAIN.
- Reset, including mid-drain: state IDLE, `tgt` IDLE, counter 0, `rd_en`=0, `wr_en`=0, `mode`=0, `timeout_err`=0.

## Timing
- All outputs are registered and decoded from the state register; no combinational path from input to output.
- Key latency: key pulse sampled at edge n -> new state, enables and `mode` valid after edge n.
- Drain minimum: entering DRAIN at edge n with `burst_busy`=0 at edge n+1 -> target state after edge n+1. This gives at least one cycle with both enables low between any READ/WRITE swap.
- Timeout: with `burst_busy` held high, DRAIN lasts exactly `TMO_CYC` cycles. `timeout_err` rises in the same cycle the target state is entered.

## Structure
- Package `ddr_rw_sched_pkg` holds:
  - state encoding localparams (`ST_IDLE`, `ST_READ`, `ST_WRITE`, `ST_DRAIN`);
  - the `TMO_CYC` derivation function (32-bit).
- Sub-module `drain_timer`:
  - Inputs: `clk`, `rst`, `en`, `clr`.
  - Parameter: `TMO_CYC`.
  - Output: `expired`.
  - Saturating 32-bit counter.
- Top level: FSM, `tgt` register, sticky error register.

## Test plan
Use `FREQ`=1000 and `TIMEOUT_MS`=5, so `TMO_CYC`=5.
- Reset then `key_rd` pulse with `burst_busy`=0 -> `rd_en`=1 one cycle later, `wr_en`=0, `mode`=1. A second `key_rd` -> DRAIN, then IDLE, both enables 0.
- In READ, `burst_busy` held 1 for 3 cycles, then `key_wr` -> DRAIN for 4 cycles with both enables 0, then `wr_en`=1, `mode`=2. Check `rd_en&wr_en` is never 1.
- In WRITE, `key_rd` and `key_wr` in the same cycle -> `key_rd` wins: DRAIN with `tgt`=READ, ends in READ.
- In DRAIN (`tgt`=READ) with `burst_busy`=1, `key_rd` pulse -> `tgt`=IDLE; on busy drop the FSM goes to IDLE, not READ.
- In DRAIN, `burst_busy` stuck at 1 -> exit to `tgt` after exactly 5 cycles, `timeout_err`=1 and held until `rst`.
- Assert `rst` for one cycle mid-DRAIN with the counter at 3 -> next cycle all outputs 0, `mode`=0. A subsequent `key_wr` -> WRITE after one cycle.

Source files
------------

// File: rtl/ddr_rw_sched_pkg.sv
// ddr_rw_sched_pkg: state encoding and drain-timeout derivation shared by the scheduler.
package ddr_rw_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic logic [31:0] tmo_cyc(input logic [31:0] freq, input logic [31:0] ms);
        return (freq / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/ddr_rw_sched_drain_timer.sv
// drain_timer: saturating 32-bit busy-cycle counter that flags the last allowed drain cycle.
module drain_timer #(
    parameter logic [31:0] TMO_CYC = 32'd5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);
    logic [31:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign expired = en && (cnt_q == TMO_CYC - 32'd1);
endmodule

// File: rtl/ddr_rw_sched.sv
// ddr_rw_sched: turns key pulses into exclusive rd_en/wr_en levels, draining the
// DDR3 controller between mode changes with a bounded wait.
module ddr_rw_sched
    import ddr_rw_sched_pkg::*;
#(
    parameter logic [27:0] FREQ       = 28'd25_000_000,
    parameter int          TIMEOUT_MS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_rd,
    input  logic       key_wr,
    input  logic       burst_busy,
    output logic       rd_en,
    output logic       wr_en,
    output logic [1:0] mode,
    output logic       timeout_err
);
    localparam logic [31:0] TMO_CYC = tmo_cyc({4'd0, FREQ}, 32'(TIMEOUT_MS));

    state_t state_q, state_d, tgt_q, tgt_d;
    logic   err_q, err_d;
    logic   tmr_en, expired;

    assign tmr_en = (state_q == ST_DRAIN) && burst_busy;

    drain_timer #(.TMO_CYC(TMO_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (tmr_en),
        .clr     (!tmr_en),
        .expired (expired)
    );

    // key_rd always beats key_wr when both arrive together
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE:  state_d = key_rd ? ST_READ : key_wr ? ST_WRITE : ST_IDLE;
            ST_READ:  if (key_rd || key_wr) begin
                state_d = ST_DRAIN;
                tgt_d   = key_rd ? ST_IDLE : ST_WRITE;
            end
            ST_WRITE: if (key_rd || key_wr) begin
                state_d = ST_DRAIN;
                tgt_d   = key_rd ? ST_READ : ST_IDLE;
            end
            default: begin
                tgt_d = key_rd ? ((tgt_q == ST_READ)  ? ST_IDLE : ST_READ)
                      : key_wr ? ((tgt_q == ST_WRITE) ? ST_IDLE : ST_WRITE)
                      : tgt_q;
                if (!burst_busy || expired) state_d = tgt_d;
                if (expired) err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk)
        if (rst) begin
            state_q <= ST_IDLE;
            tgt_q   <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            err_q   <= err_d;
        end

    assign rd_en       = (state_q == ST_READ);
    assign wr_en       = (state_q == ST_WRITE);
    assign mode        = state_q;
    assign timeout_err = err_q;
endmodule

// File: tb/tb_ddr_rw_sched.sv
// tb_ddr_rw_sched: directed plan sequences plus random traffic against a behavioural mode model.
module tb_ddr_rw_sched;
    localparam int TMO = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_rd = 1'b0;
    logic       key_wr = 1'b0;
    logic       burst_busy = 1'b0;
    logic       rd_en, wr_en, timeout_err;
    logic [1:0] mode;

    int n_chk = 0;
    int n_pass = 0;

    // reference model: current mode, mode to resume after drain, busy cycles waited, error flag
    int m_mode = 0;
    int m_tgt = 0;
    int m_wait = 0;
    int m_err = 0;

    ddr_rw_sched #(.FREQ(28'd1000), .TIMEOUT_MS(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_rd      (key_rd),
        .key_wr      (key_wr),
        .burst_busy  (burst_busy),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .mode        (mode),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit kr, input bit kw, input bit bb);
        if (r) begin
            m_mode = 0; m_tgt = 0; m_wait = 0; m_err = 0;
        end else if (m_mode == 0) begin
            if (kr) m_mode = 1;
            else if (kw) m_mode = 2;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (kr || kw) begin
                // pressing the active mode's key stops; pressing the other key swaps
                int want = kr ? 1 : 2;
                m_tgt  = (want == m_mode) ? 0 : want;
                m_mode = 3;
                m_wait = 0;
            end
        end else begin
            if (kr) m_tgt = (m_tgt == 1) ? 0 : 1;
            else if (kw) m_tgt = (m_tgt == 2) ? 0 : 2;
            if (!bb) begin
                m_mode = m_tgt; m_wait = 0;
            end else if (m_wait == TMO - 1) begin
                m_mode = m_tgt; m_wait = 0; m_err = 1;
            end else m_wait++;
        end
    endtask

    task automatic cyc(input bit r, input bit kr, input bit kw, input bit bb);
        rst = r; key_rd = kr; key_wr = kw; burst_busy = bb;
        @(posedge clk);
        model_step(r, kr, kw, bb);
        #1;
        check("rd_en", 32'(rd_en), 32'(m_mode == 1));
        check("wr_en", 32'(wr_en), 32'(m_mode == 2));
        check("mode", 32'(mode), 32'(m_mode));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        check("exclusive", 32'(rd_en & wr_en), 32'd0);
        rst = 1'b0; key_rd = 1'b0; key_wr = 1'b0;
    endtask

    initial begin
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("reset_mode", 32'(mode), 32'd0);
        // read on, then read again stops via drain
        cyc(0, 1, 0, 0);
        check("first_read", 32'({rd_en, wr_en, mode}), 32'b10_01);
        cyc(0, 1, 0, 0);
        check("stop_drain", 32'(mode), 32'd3);
        cyc(0, 0, 0, 0);
        check("stop_idle", 32'({rd_en, wr_en, mode}), 32'b00_00);
        // read -> write swap with busy controller
        cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        repeat (3) begin
            cyc(0, 0, 0, 1);
            check("swap_drain", 32'({rd_en, wr_en, mode}), 32'b00_11);
        end
        cyc(0, 0, 0, 0);
        check("swap_write", 32'({rd_en, wr_en, mode}), 32'b01_10);
        // simultaneous keys in WRITE: read wins
        cyc(0, 1, 1, 0);
        check("both_drain", 32'(mode), 32'd3);
        cyc(0, 0, 0, 0);
        check("both_read", 32'(mode), 32'd1);
        // retarget in DRAIN: WRITE -> READ -> IDLE
        cyc(0, 0, 1, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 0);
        check("retarget_idle", 32'(mode), 32'd0);
        // timeout with busy stuck high
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 1);
        repeat (4) begin
            cyc(0, 0, 0, 1);
            check("tmo_wait", 32'({mode, timeout_err}), 32'b11_0);
        end
        cyc(0, 0, 0, 1);
        check("tmo_exit", 32'({mode, timeout_err}), 32'b10_1);
        repeat (3) cyc(0, 0, 0, 1);
        check("tmo_sticky", 32'(timeout_err), 32'd1);
        // reset mid-drain with counter at 3
        cyc(0, 0, 1, 1);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        check("rst_drain", 32'({rd_en, wr_en, mode, timeout_err}), 32'd0);
        cyc(0, 0, 1, 0);
        check("rst_then_write", 32'(mode), 32'd2);
        // random traffic with bursty busy
        for (int i = 0; i < 4000; i++) begin
            bit r  = ($urandom_range(299) == 0);
            bit kr = ($urandom_range(7) == 0);
            bit kw = ($urandom_range(7) == 0);
            bit bb = ($urandom_range(9) < (i % 200 < 100 ? 9 : 4));
            cyc(r, kr, kw, bb);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
